// File: rtl/ps2_key_if.sv
// ps2_key_if: PS/2 pin pair plus decoded key event bundle.
// master: keyboard/consumer side (drives ps2_clk/ps2_data, observes key events)
// slave : decoder side (samples ps2_clk/ps2_data, drives key events)
interface ps2_key_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_ext;
    logic       key_break;
    logic       dir_up;
    logic       dir_down;
    logic       dir_left;
    logic       dir_right;
    logic       frame_err;
    modport master (
        output ps2_clk, ps2_data,
        input  key_code, key_valid, key_ext, key_break,
        input  dir_up, dir_down, dir_left, dir_right, frame_err
    );
    modport slave (
        input  ps2_clk, ps2_data,
        output key_code, key_valid, key_ext, key_break,
        output dir_up, dir_down, dir_left, dir_right, frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver resolving E0/F0 prefixes into key events and arrow-held flags.
// Ports: clk, rst_n (async active-low); bus (ps2_key_if.slave): ps2_clk/ps2_data in,
//        key_code/key_valid/key_ext/key_break, dir_up/down/left/right, frame_err out.
// Optional: define TYPEMATIC_SUPPRESS_EN to drop repeated makes of the last key until its break.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic   clk,
    input  logic   rst_n,
    ps2_key_if.slave bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {RX_IDLE, RX_BITS} rx_t;
    typedef enum logic [1:0] {SQ_BASE, SQ_EXT, SQ_BRK, SQ_EXT_BRK} sq_t;

    logic [1:0]    clk_s_q, dat_s_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    rx_t           rx_q, rx_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    sr_q, sr_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    sq_t           sq_q, sq_d;
    logic [7:0]    code_q, code_d;
    logic          ext_q, ext_d, brk_q, brk_d, valid_q, valid_d, err_q, err_d;
    logic [3:0]    dir_q, dir_d;
    logic          fall, din, byte_rdy, bad, is_ext, is_brk, supp;
`ifdef TYPEMATIC_SUPPRESS_EN
    logic [8:0]    last_q, last_d;
    logic          last_v_q, last_v_d;
`endif

    assign din = dat_s_q[1];

    always_comb begin
        filt_d   = filt_q;
        fcnt_d   = fcnt_q;
        rx_d     = rx_q;
        bit_d    = bit_q;
        sr_d     = sr_q;
        par_d    = par_q;
        to_d     = to_q;
        sq_d     = sq_q;
        code_d   = code_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        dir_d    = dir_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        fall     = 1'b0;
        byte_rdy = 1'b0;
        bad      = 1'b0;
        supp     = 1'b0;
`ifdef TYPEMATIC_SUPPRESS_EN
        last_d   = last_q;
        last_v_d = last_v_q;
`endif
        // Filtered clock flips only after FILTER_LEN consecutive samples disagreeing with it
        if (clk_s_q[1] == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = clk_s_q[1];
            fcnt_d = '0;
            fall   = filt_q;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end
        if (rx_q == RX_IDLE) begin
            to_d = '0;
            if (fall && !din) begin
                rx_d  = RX_BITS;
                bit_d = 4'd1;
            end
        end else if (fall) begin
            to_d  = '0;
            bit_d = bit_q + 4'd1;
            if (bit_q <= 4'd8) begin
                sr_d = {din, sr_q[7:1]};
            end else if (bit_q == 4'd9) begin
                par_d = din;
            end else begin
                rx_d     = RX_IDLE;
                byte_rdy = din && (^sr_q ^ par_q);
                bad      = !byte_rdy;
            end
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            rx_d = RX_IDLE;
            bad  = 1'b1;
        end else begin
            to_d = to_q + 1'b1;
        end
        is_ext = (sq_q == SQ_EXT) || (sq_q == SQ_EXT_BRK);
        is_brk = (sq_q == SQ_BRK) || (sq_q == SQ_EXT_BRK);
        if (bad) begin
            err_d = 1'b1;
            sq_d  = SQ_BASE;
`ifdef TYPEMATIC_SUPPRESS_EN
            last_v_d = 1'b0;
`endif
        end else if (byte_rdy) begin
            if (!is_brk && sr_q == 8'hF0) begin
                sq_d = is_ext ? SQ_EXT_BRK : SQ_BRK;
            end else if (!is_brk && sr_q == 8'hE0) begin
                sq_d = SQ_EXT;
            end else begin
                sq_d = SQ_BASE;
`ifdef TYPEMATIC_SUPPRESS_EN
                supp = !is_brk && last_v_q && (last_q == {is_ext, sr_q});
                if (!is_brk) begin
                    last_d   = {is_ext, sr_q};
                    last_v_d = 1'b1;
                end else if (last_q == {is_ext, sr_q}) begin
                    last_v_d = 1'b0;
                end
`endif
                if (!supp) begin
                    code_d  = sr_q;
                    ext_d   = is_ext;
                    brk_d   = is_brk;
                    valid_d = 1'b1;
                end
                // Arrow flags follow every extended event, suppressed or not
                if (is_ext && sr_q == 8'h75) dir_d[0] = !is_brk;
                if (is_ext && sr_q == 8'h72) dir_d[1] = !is_brk;
                if (is_ext && sr_q == 8'h6B) dir_d[2] = !is_brk;
                if (is_ext && sr_q == 8'h74) dir_d[3] = !is_brk;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s_q  <= 2'b11;
            dat_s_q  <= 2'b11;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            rx_q     <= RX_IDLE;
            bit_q    <= '0;
            sr_q     <= '0;
            par_q    <= 1'b0;
            to_q     <= '0;
            sq_q     <= SQ_BASE;
            code_q   <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            dir_q    <= '0;
`ifdef TYPEMATIC_SUPPRESS_EN
            last_q   <= '0;
            last_v_q <= 1'b0;
`endif
        end else begin
            clk_s_q  <= {clk_s_q[0], bus.ps2_clk};
            dat_s_q  <= {dat_s_q[0], bus.ps2_data};
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            rx_q     <= rx_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
            par_q    <= par_d;
            to_q     <= to_d;
            sq_q     <= sq_d;
            code_q   <= code_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            dir_q    <= dir_d;
`ifdef TYPEMATIC_SUPPRESS_EN
            last_q   <= last_d;
            last_v_q <= last_v_d;
`endif
        end
    end

    assign bus.key_code  = code_q;
    assign bus.key_valid = valid_q;
    assign bus.key_ext   = ext_q;
    assign bus.key_break = brk_q;
    assign bus.dir_up    = dir_q[0];
    assign bus.dir_down  = dir_q[1];
    assign bus.dir_left  = dir_q[2];
    assign bus.dir_right = dir_q[3];
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed-vector bench for ps2_key_decoder.
module tb_ps2_key_decoder;
    localparam int FL = 8;
    localparam int TO = 2000;
`ifdef TYPEMATIC_SUPPRESS_EN
    localparam int TYPE_EXP = 1;
`else
    localparam int TYPE_EXP = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0, n_fail = 0;
    int   n_valid = 0, n_err = 0, n_overlap = 0;
    int   v0, e0;

    ps2_key_if bus();

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.key_valid) n_valid++;
        if (bus.frame_err) n_err++;
        if (bus.key_valid && bus.frame_err) n_overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clock_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = f[i];
            repeat (10) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (20) @(negedge clk);
            bus.ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic inv_par);
        clock_bits({1'b1, (~^b) ^ inv_par, b, 1'b0}, 11);
        bus.ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    function automatic logic [3:0] dirs();
        return {bus.dir_right, bus.dir_left, bus.dir_down, bus.dir_up};
    endfunction

    function automatic logic [14:0] all_out();
        return {bus.key_code, bus.key_valid, bus.key_ext, bus.key_break, dirs(), bus.frame_err};
    endfunction

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_outputs", 32'(all_out()), 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        v0 = n_valid;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("up_make_count", n_valid - v0, 1);
        check("up_make_code", bus.key_code, 8'h75);
        check("up_make_ext", bus.key_ext, 1);
        check("up_make_brk", bus.key_break, 0);
        check("up_make_dirs", dirs(), 4'b0001);

        v0 = n_valid;
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("up_brk_count", n_valid - v0, 1);
        check("up_brk_code", bus.key_code, 8'h75);
        check("up_brk_ext", bus.key_ext, 1);
        check("up_brk_brk", bus.key_break, 1);
        check("up_brk_dirs", dirs(), 4'b0000);

        v0 = n_valid; e0 = n_err;
        send_byte(8'h1C, 1'b1);
        check("par_err_count", n_err - e0, 1);
        check("par_err_valid", n_valid - v0, 0);
        v0 = n_valid;
        send_byte(8'h1C, 1'b0);
        check("a_count", n_valid - v0, 1);
        check("a_code", bus.key_code, 8'h1C);
        check("a_ext", bus.key_ext, 0);
        check("a_brk", bus.key_break, 0);

        e0 = n_err;
        clock_bits(11'b000_1010_0000, 5);
        repeat (TO + 50) @(negedge clk);
        check("timeout_err", n_err - e0, 1);
        v0 = n_valid;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h6B, 1'b0);
        check("left_count", n_valid - v0, 1);
        check("left_dirs", dirs(), 4'b0100);
        check("timeout_total_err", n_err - e0, 1);

        v0 = n_valid;
        send_byte(8'h72, 1'b0);
        check("kp2_count", n_valid - v0, 1);
        check("kp2_ext", bus.key_ext, 0);
        check("kp2_dirs", dirs(), 4'b0100);

        e0 = n_err; v0 = n_valid;
        bus.ps2_data = 1'b0;
        bus.ps2_clk  = 1'b0;
        repeat (FL - 2) @(negedge clk);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (30) @(negedge clk);
        send_byte(8'h29, 1'b0);
        check("glitch_err", n_err - e0, 0);
        check("glitch_count", n_valid - v0, 1);
        check("glitch_code", bus.key_code, 8'h29);

        e0 = n_err; v0 = n_valid;
        clock_bits(11'b000_0000_1010, 4);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_outputs", 32'(all_out()), 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_pulses", (n_err - e0) + (n_valid - v0), 0);
        send_byte(8'h1C, 1'b0);
        check("post_rst_count", n_valid - v0, 1);
        check("post_rst_code", bus.key_code, 8'h1C);

        v0 = n_valid;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hE0, 1'b0);
            send_byte(8'h74, 1'b0);
        end
        check("typematic_count", n_valid - v0, TYPE_EXP);
        check("typematic_code", bus.key_code, 8'h74);
        check("typematic_dirs", dirs(), 4'b1000);

        check("no_overlap", n_overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives raw PS/2 keyboard frames and resolves the E0/F0 prefix sequences into single key events.
- Produces the 8-bit `key_code` and per-arrow held-direction flags consumed by the maze movement stage.
- Sits directly upstream of the movement logic; it is the only block touching the PS/2 pins.

Parameters:
- FILTER_LEN, 8: consecutive identical samples needed before the filtered ps2_clk changes state.
- TIMEOUT_CYCLES, 50000: clk cycles without a falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
- ps2_data  input  1  raw PS/2 data, asynchronous.
- key_code  output  8  last decoded scan code, prefixes stripped.
- key_valid  output  1  one-cycle pulse: key_code/key_ext/key_break updated.
- key_ext  output  1  event carried the E0 prefix.
- key_break  output  1  event was a release (F0 prefix).
- dir_up, dir_down, dir_left, dir_right  output  1 each  arrow currently held.
- frame_err  output  1  one-cycle pulse on start/parity/stop error or timeout.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0.
  - Both FSMs go to their idle states.
  - Filter state is forced high and counters are cleared.
  - Reset mid-frame discards the partial frame; no pulse is issued.
- Input conditioning:
  - ps2_clk and ps2_data pass through 2-flop synchronizers.
  - Filtered clock changes state only after FILTER_LEN consecutive equal synced samples.
  - A falling edge of the filtered clock is a one-cycle strobe `fall`.
- Frame FSM:
  - RX_IDLE: a `fall` with data=0 moves to RX_BITS with bit count 1. A `fall` with data=1 is ignored and the FSM stays idle.
  - RX_BITS: each `fall` samples data.
    - Bits 1-8: data, LSB first.
    - Bit 9: parity. Odd parity is required over data plus parity bit.
    - Bit 10: stop, must be 1.
  - After bit 10, return to RX_IDLE.
  - On a good frame, `byte_rdy` strobes for one cycle. On a bad frame, `frame_err` pulses and the sequence FSM returns to SQ_BASE.
- Timeout:
  - In RX_BITS, a counter resets on each `fall`.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to RX_IDLE, `frame_err` pulses, and the sequence FSM returns to SQ_BASE.
- Sequence FSM, acting on `byte_rdy`:
  - SQ_BASE: E0 -> SQ_EXT; F0 -> SQ_BRK; other -> emit(make, ext=0).
  - SQ_EXT: F0 -> SQ_EXT_BRK; E0 -> stay; other -> emit(make, ext=1) -> SQ_BASE.
  - SQ_BRK: any byte -> emit(break, ext=0) -> SQ_BASE.
  - SQ_EXT_BRK: any byte -> emit(break, ext=1) -> SQ_BASE.
- Emit timing:
  - key_code, key_ext and key_break are registered, and key_valid is high on the clk cycle after the `fall` that sampled the stop bit.
  - Total latency is that `fall` + 1 cycle.
  - key_code, key_ext and key_break hold their values until the next emit.
- Direction flags:
  - Changed only by ext=1 events: 75 = up, 72 = down, 6B = left, 74 = right.
  - Make sets the flag; break clears it.
  - Non-extended codes (keypad 8/2/4/6) never change the flags.
  - Several flags may be high at once.
  - A flag is set or cleared in the same cycle key_valid asserts.
- Simultaneous events:
  - A timeout and a `fall` in the same cycle: the `fall` wins and the counter clears.
  - frame_err and key_valid never assert in the same cycle.

Optional Feature:
- Macro: TYPEMATIC_SUPPRESS_EN.
- Defined: a make event whose key_code and key_ext equal the last emitted make, with no intervening break of that key, produces no key_valid pulse. Direction flags are unaffected. The memory clears on the matching break, on frame_err, and on reset.
- Undefined: every make, including keyboard auto-repeat, pulses key_valid.

Test Plan:
- Frames E0, 75 -> one key_valid; key_code=0x75, key_ext=1, key_break=0, dir_up=1, all other dirs 0.
- Then frames E0, F0, 75 -> key_valid with key_code=0x75, key_ext=1, key_break=1; dir_up=0.
- Frame 0x1C with parity bit inverted -> frame_err pulse, no key_valid; a following good 0x1C -> key_valid, key_code=0x1C, key_ext=0.
- Start bit plus 4 data bits, then idle TIMEOUT_CYCLES+2 -> exactly one frame_err; next frame 0x6B prefixed by E0 -> dir_left=1.
- ps2_clk low glitch of FILTER_LEN-2 cycles mid-idle -> no bit sampled; assert rst_n low mid-frame -> all outputs 0, the next full frame decodes correctly.
- E0 74 sent three times (typematic) -> 3 key_valid pulses with the macro undefined, 1 with TYPEMATIC_SUPPRESS_EN defined; dir_right=1 in both cases.
